// File: rtl/dmem_resp.sv
// Data-memory responder for the MEM stage: word-addressed RAM with wait states and a pipeline stall.
// Optional macro DMEM_MISALIGN_TRAP_EN adds a misalignm output that traps non-word-aligned requests.
module dmem_resp #(
   parameter int DEPTH_LOG2  = 6,
   parameter int WAIT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        memwritem,
   input  logic        memtoregm,
   input  logic [31:0] aluoutm,
   input  logic [31:0] writedatam,
   output logic [31:0] readdatam,
`ifdef DMEM_MISALIGN_TRAP_EN
   output logic        misalignm,
`endif
   output logic        stallm
);

   localparam int DEPTH = 1 << DEPTH_LOG2;

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_ACCESS,
      S_DONE
   } state_t;

   state_t                state_q, state_d;
   logic [3:0]            cnt_q, cnt_d;
   logic [DEPTH_LOG2-1:0] idx_q, idx_d;
   logic [31:0]           data_q, data_d;
   logic                  write_q, write_d;
   logic [31:0]           readData_q, readData_d;
   logic                  ramWe;
   logic                  req;
   logic [DEPTH_LOG2-1:0] reqIdx;

   logic [31:0] ram [DEPTH];

   assign req    = memwritem | memtoregm;
   assign reqIdx = aluoutm[DEPTH_LOG2+1:2];

`ifdef DMEM_MISALIGN_TRAP_EN
   logic misalign_q, misalign_d;
   logic misReq;
   logic unusedAddr;

   assign misReq     = (aluoutm[1:0] != 2'b00);
   assign unusedAddr = ^aluoutm[31:DEPTH_LOG2+2];
   assign misalignm  = misalign_q;
`else
   logic unusedAddr;

   assign unusedAddr = ^{aluoutm[31:DEPTH_LOG2+2], aluoutm[1:0]};
`endif

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      idx_d      = idx_q;
      data_d     = data_q;
      write_d    = write_q;
      readData_d = readData_q;
      ramWe      = 1'b0;
      stallm     = 1'b0;
`ifdef DMEM_MISALIGN_TRAP_EN
      misalign_d = 1'b0;
`endif
      case (state_q)
         S_IDLE: begin
            if (req) begin
               stallm  = 1'b1;
               idx_d   = reqIdx;
               data_d  = writedatam;
               write_d = memwritem;
               cnt_d   = 4'(WAIT_CYCLES);
`ifdef DMEM_MISALIGN_TRAP_EN
               if (misReq) begin
                  state_d    = S_DONE;
                  misalign_d = 1'b1;
               end else begin
                  state_d = (WAIT_CYCLES > 0) ? S_WAIT : S_ACCESS;
               end
`else
               state_d = (WAIT_CYCLES > 0) ? S_WAIT : S_ACCESS;
`endif
            end
         end
         S_WAIT: begin
            stallm = 1'b1;
            cnt_d  = cnt_q - 4'd1;
            if (cnt_q <= 4'd1) begin
               state_d = S_ACCESS;
            end
         end
         S_ACCESS: begin
            // A simultaneous read+write request was latched as a write, so no load happens here.
            stallm  = 1'b1;
            state_d = S_DONE;
            if (write_q) begin
               ramWe = 1'b1;
            end else begin
               readData_d = ram[idx_q];
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_IDLE;
         cnt_q      <= 4'd0;
         idx_q      <= '0;
         data_q     <= 32'd0;
         write_q    <= 1'b0;
         readData_q <= 32'd0;
`ifdef DMEM_MISALIGN_TRAP_EN
         misalign_q <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         idx_q      <= idx_d;
         data_q     <= data_d;
         write_q    <= write_d;
         readData_q <= readData_d;
`ifdef DMEM_MISALIGN_TRAP_EN
         misalign_q <= misalign_d;
`endif
      end
   end

   // RAM is never cleared; reset only blocks a write that lands on the same edge.
   always_ff @(posedge clk) begin
      if (!reset && ramWe) begin
         ram[idx_q] <= data_q;
      end
   end

   assign readdatam = readData_q;

endmodule

// File: doc/dmem_resp.md
Name: dmem_resp

Overview:
- Data-memory responder at the far end of the MEM-stage interface of the pipelined MIPS core.
- Consumes the MEM-stage request: memwritem, memtoregm, aluoutm, writedatam.
- Holds a word-addressed RAM with a configurable number of wait states.
- Asserts stallm to freeze the pipeline until the access completes, then returns registered read data (readdatam) toward the MEM/WB register.

Parameters:
- DEPTH_LOG2, 6: RAM holds 2**DEPTH_LOG2 32-bit words.
- WAIT_CYCLES, 2: extra wait-state cycles per access. Legal range 0..15.

Ports:
- clk, input, 1: rising-edge clock.
- reset, input, 1: synchronous, active-high reset.
- memwritem, input, 1: write request.
- memtoregm, input, 1: read request (load).
- aluoutm, input, 32: byte address.
- writedatam, input, 32: store data.
- readdatam, output, 32: registered load data.
- stallm, output, 1: pipeline stall request.

Behaviour:
- Request definition: req = memwritem | memtoregm. If both are high, the access is a write only; readdatam is unchanged.
- Word index: aluoutm[DEPTH_LOG2+1:2].
  - aluoutm[31:DEPTH_LOG2+2] is ignored, so addresses wrap modulo the RAM size.
  - aluoutm[1:0] is ignored unless the optional feature is enabled.
- FSM states: IDLE, WAIT, ACCESS, DONE. 4-bit down-counter cnt.
- IDLE:
  - If req: latch index, data and type; cnt <= WAIT_CYCLES.
  - Next state is WAIT if WAIT_CYCLES > 0, otherwise ACCESS.
  - If no req: stay in IDLE.
- WAIT: cnt decrements each cycle. When cnt == 1, go to ACCESS.
- ACCESS:
  - Write: RAM[index] <= data at the clock edge.
  - Read: readdatam <= RAM[index] at the clock edge.
  - Always go to DONE.
- DONE:
  - The access is complete. The pipeline advances at the end of this cycle.
  - Inputs are not sampled in DONE. Always go to IDLE.
- stallm (combinational) = (IDLE && req) || WAIT || ACCESS.
- Stall cycles per access = WAIT_CYCLES + 2; stallm is low in DONE.
- Back-to-back accesses: after DONE, a new request seen in IDLE starts a new access. There is 1 idle cycle of non-stall (DONE) between accesses.
- readdatam:
  - Valid from the DONE cycle onward.
  - Held until the next read completes.
  - Never changed by writes.
- Reset values: state IDLE, cnt 0, readdatam 0, stallm 0. RAM contents are not reset.
- Reset mid-operation:
  - Any request in WAIT is abandoned and the RAM is not written.
  - Reset takes priority over the ACCESS-edge write/read: that write does not occur.
- Request inputs must be held stable while stallm is high. The hazard unit guarantees this by holding the EX/MEM register; the responder uses its latched copies regardless.

Optional Feature:
- Macro: DMEM_MISALIGN_TRAP_EN.
- Defined:
  - Adds output port misalignm (1 bit; reset 0).
  - A request with aluoutm[1:0] != 0 goes IDLE -> DONE directly, giving 1 stall cycle.
  - No RAM access occurs and readdatam is unchanged.
  - misalignm is high for exactly the DONE cycle.
  - Aligned requests behave exactly as without the macro.
- Undefined: no misalignm port; aluoutm[1:0] is ignored.

Test Plan:
- Reset: hold reset for 2 cycles mid-run -> readdatam=0x00000000, stallm=0, FSM in IDLE next cycle.
- Write/read (WAIT_CYCLES=2): write 0xDEADBEEF to 0x10, then read 0x10 -> stallm high exactly 4 cycles per access; readdatam=0xDEADBEEF in the read's DONE cycle.
- Wrap (DEPTH_LOG2=6): write 0x12345678 to 0x00000104, read 0x00000004 -> readdatam=0x12345678.
- Simultaneous: memwritem=memtoregm=1, address 0x08, data 0xCAFEF00D, with prior readdatam=0x12345678 -> readdatam stays 0x12345678; a subsequent read of 0x08 returns 0xCAFEF00D.
- Reset mid-op: RAM[0x20]=0x11111111; start write 0xAAAA5555 to 0x20; assert reset in the first WAIT cycle; then read 0x20 -> 0x11111111.
- WAIT_CYCLES=0 build: read 0x10 -> stallm high exactly 2 cycles. With DMEM_MISALIGN_TRAP_EN: read 0x22 -> stallm high 1 cycle, misalignm=1 for one cycle, readdatam unchanged.
